// File: rtl/uart_pkg.sv
// uart_pkg: state encodings, defaults and frame-length helper shared by the UART transmitter and receiver.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;

    localparam int CLKS_PER_BIT_DEF = 16;

    // Clock cycles from the first START cycle to the first IDLE cycle.
    function automatic int frame_len(input int clks_per_bit, input int parity_en, input int stop_bits);
        return clks_per_bit * (1 + 8 + parity_en + stop_bits);
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each serial bit.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic arstn,
    input  logic clr_i,
    output logic tick_o
);
    localparam int W = $clog2(CLKS_PER_BIT);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = cnt_q == W'(CLKS_PER_BIT - 1);

    always_comb cnt_d = (clr_i || tick_o) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: serializes a handshaked byte as start, 8 data bits LSB first, optional parity, stop bit(s).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       arstn,
    input  logic       en,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       ready,
    output logic       q,
    output logic       active,
    output logic       done
);
    uart_state_e state_q, state_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic        q_q, q_d;
    logic        ready_q, ready_d;
    logic        active_q, active_d;
    logic        done_q, done_d;
    logic        tick;

    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .arstn (arstn),
        .clr_i (state_q == IDLE),
        .tick_o(tick)
    );

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        case (state_q)
            IDLE: if (ready_q && data_valid) begin
                state_d = START;
                shift_d = data_in;
                par_d   = ^data_in ^ (PARITY_ODD != 0);
            end
            START: if (tick) begin
                state_d = DATA;
                bit_d   = 3'd0;
            end
            DATA: if (tick) begin
                shift_d = shift_q >> 1;
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    bit_d   = 3'd0;
                end
            end
            PARITY: if (tick) state_d = STOP;
            STOP: if (tick) begin
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'(STOP_BITS - 1)) begin
                    state_d = IDLE;
                    bit_d   = 3'd0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are decoded from next-state values so the registers line up with the state.
        q_d      = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_d : 1'b1;
        ready_d  = state_d == IDLE && en;
        active_d = state_d != IDLE;
        done_d   = state_q == STOP && state_d == IDLE;
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q  <= IDLE;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            q_q      <= 1'b1;
            ready_q  <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            q_q      <= q_d;
            ready_q  <= ready_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign ready  = ready_q;
    assign q      = q_q;
    assign active = active_q;
    assign done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven frames checked through a scoreboard, plus back-to-back, reset-abort and enable corners.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CPB = 4;
    localparam int F   = frame_len(CPB, 1, 1);

    logic       clk = 1'b0;
    logic       arstn = 1'b0;
    logic       en = 1'b0;
    logic       data_valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       ready, q, active, done;
    logic       ready2, q2, active2, done2;

    int checks = 0, fails = 0;
    int cyc_n = 0, n_frames = 0, n_done = 0, pitch = 0;
    int fc = 0, prev_start = -1;
    bit in_f = 1'b0;
    logic [F-1:0] wave;
    logic [10:0]  exp_q[$];

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       po;
    } vec_t;
    vec_t vecs[10];

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut (
        .clk(clk), .arstn(arstn), .en(en), .data_in(data_in), .data_valid(data_valid),
        .ready(ready), .q(q), .active(active), .done(done)
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_odd (
        .clk(clk), .arstn(arstn), .en(en), .data_in(data_in), .data_valid(data_valid),
        .ready(ready2), .q(q2), .active(active2), .done(done2)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc_n++;
    end

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endfunction

    function automatic logic [F-1:0] expand(input logic [10:0] b);
        logic [F-1:0] r;
        for (int i = 0; i < F; i++) r[i] = b[i / CPB];
        return r;
    endfunction

    // Frame monitor: records q per cycle while active, compares against the scoreboard at the first idle cycle.
    initial forever begin
        @(negedge clk);
        if (!arstn) in_f = 1'b0;
        else begin
            if (done) n_done++;
            if (active) begin
                if (!in_f) begin
                    in_f = 1'b1;
                    fc = 0;
                    wave = '0;
                    if (prev_start >= 0) pitch = cyc_n - prev_start;
                    prev_start = cyc_n;
                end
                if (fc < F) wave[fc] = q;
                fc++;
            end else if (in_f) begin
                in_f = 1'b0;
                n_frames++;
                chk("frame_len", fc, F);
                chk("done_first_idle", done, 1);
                chk("sb_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("frame_bits", wave, expand(exp_q.pop_front()));
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic pe, input bit hold);
        int n = 0;
        data_in = d;
        data_valid = 1'b1;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", ready, 1);
        if (!ready) begin
            data_valid = 1'b0;
            return;
        end
        exp_q.push_back({1'b1, pe, d, 1'b0});
        @(negedge clk);
        if (!hold) data_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (active && n < 4 * F) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", active, 0);
        chk("odd_done", done2, 1);
        @(negedge clk);
    endtask

    initial begin
        int base, nd, bad;
        vecs = '{'{8'hA5, 1'b0, 1'b1}, '{8'h07, 1'b1, 1'b0}, '{8'h3C, 1'b0, 1'b1},
                 '{8'hC3, 1'b0, 1'b1}, '{8'h55, 1'b0, 1'b1}, '{8'h00, 1'b0, 1'b1},
                 '{8'hFF, 1'b0, 1'b1}, '{8'h01, 1'b1, 1'b0}, '{8'h80, 1'b1, 1'b0},
                 '{8'h0B, 1'b1, 1'b0}};
        repeat (3) begin
            @(negedge clk);
            chk("rst_outs", {q, active, done, ready}, 4'b1000);
        end
        arstn = 1'b1;
        @(negedge clk);
        chk("ready_en0", ready, 0);
        en = 1'b1;
        @(negedge clk);
        chk("ready_en1", ready, 1);

        foreach (vecs[i]) begin
            send(vecs[i].d, vecs[i].pe, 1'b0);
            repeat (37) @(negedge clk);
            chk("parity_odd", q2, vecs[i].po);
            chk("odd_busy", {active2, ready2}, 2'b10);
            wait_idle();
        end

        base = n_frames;
        send(8'h3C, 1'b0, 1'b1);
        send(8'hC3, 1'b0, 1'b0);
        wait_idle();
        chk("b2b_pitch", pitch, F + 1);
        chk("b2b_frames", n_frames - base, 2);

        nd = n_done;
        send(8'h96, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        arstn = 1'b0;
        #1;
        chk("abort_line", {q, active}, 2'b10);
        void'(exp_q.pop_front());
        repeat (3) @(negedge clk);
        arstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_no_done", n_done, nd);
        send(8'h55, 1'b0, 1'b0);
        wait_idle();

        nd = n_done;
        send(8'h0B, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        en = 1'b0;
        wait_idle();
        chk("en_drop_done", n_done - nd, 1);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (ready || active) bad++;
        end
        chk("en_low_no_start", bad, 0);
        en = 1'b1;
        send(8'h0B, 1'b1, 1'b0);
        wait_idle();

        chk("frames_total", n_frames, 15);
        chk("done_total", n_done, 15);
        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, fails);
        $fatal(1);
    end

endmodule
